// File: rtl/fixed_vec3_pkg.sv
// fixed_vec3_pkg
//   Shared types and helpers for the fixed-point 3-vector unit.
//   - vec_op_e   : per-transaction operation select
//   - sat_max/sat_min/sat_clip : signed saturation bounds and clamp for an
//     arbitrary result width (used only when FIXED_VEC3_SAT_EN is defined)
package fixed_vec3_pkg;

    typedef enum logic [1:0] {
        OP_CROSS = 2'd0,
        OP_DOT   = 2'd1,
        OP_SCALE = 2'd2,
        OP_RSVD  = 2'd3
    } vec_op_e;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int w);
        if (v > sat_max(w)) begin
            return sat_max(w);
        end
        if (v < sat_min(w)) begin
            return sat_min(w);
        end
        return v;
    endfunction

endpackage

// File: rtl/fixed_mult.sv
// fixed_mult
//   Combinational signed fixed-point multiply: full-width product, arithmetic
//   shift right by FRAC_BITS (floor), then narrowed to TOTAL_PREC bits.
//   Build option FIXED_VEC3_SAT_EN: narrowing saturates instead of wrapping.
// Ports:
//   x, y : signed TOTAL_PREC-bit operands
//   p    : signed TOTAL_PREC-bit result
module fixed_mult
    import fixed_vec3_pkg::*;
#(
    parameter int TOTAL_PREC = 27,
    parameter int FRAC_BITS  = 22
) (
    input  logic signed [TOTAL_PREC-1:0] x,
    input  logic signed [TOTAL_PREC-1:0] y,
    output logic signed [TOTAL_PREC-1:0] p
);

    localparam int PW = 2 * TOTAL_PREC;

    logic signed [PW-1:0] full;
    logic signed [PW-1:0] shifted;

    always_comb begin
        full    = PW'(x) * PW'(y);
        shifted = full >>> FRAC_BITS;
`ifdef FIXED_VEC3_SAT_EN
        p = TOTAL_PREC'(sat_clip(64'(shifted), TOTAL_PREC));
`else
        p = TOTAL_PREC'(shifted);
`endif
    end

endmodule

// File: rtl/fixed_vec3_prod.sv
// fixed_vec3_prod
//   Stage-2 product generation. Routes operand pairs to six multipliers
//   according to the op; unused multipliers see zero operands.
//   Build option FIXED_VEC3_SAT_EN is honoured inside fixed_mult.
// Ports:
//   op : operation of the transaction in stage 1
//   a  : operand vector A (stage 1)
//   b  : operand vector B (stage 1)
//   p  : six products, layout per op:
//        cross: a1b2, a2b1, a2b0, a0b2, a0b1, a1b0
//        dot  : a0b0, a1b1, a2b2, 0, 0, 0
//        scale: a0b0, a1b0, a2b0, 0, 0, 0
module fixed_vec3_prod
    import fixed_vec3_pkg::*;
#(
    parameter int TOTAL_PREC = 27,
    parameter int FRAC_BITS  = 22
) (
    input  vec_op_e                      op,
    input  logic signed [TOTAL_PREC-1:0] a [3],
    input  logic signed [TOTAL_PREC-1:0] b [3],
    output logic signed [TOTAL_PREC-1:0] p [6]
);

    logic signed [TOTAL_PREC-1:0] x [6];
    logic signed [TOTAL_PREC-1:0] y [6];

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            x[i] = '0;
            y[i] = '0;
        end
        case (op)
            OP_CROSS: begin
                x[0] = a[1]; y[0] = b[2];
                x[1] = a[2]; y[1] = b[1];
                x[2] = a[2]; y[2] = b[0];
                x[3] = a[0]; y[3] = b[2];
                x[4] = a[0]; y[4] = b[1];
                x[5] = a[1]; y[5] = b[0];
            end
            OP_DOT: begin
                x[0] = a[0]; y[0] = b[0];
                x[1] = a[1]; y[1] = b[1];
                x[2] = a[2]; y[2] = b[2];
            end
            OP_SCALE: begin
                x[0] = a[0]; y[0] = b[0];
                x[1] = a[1]; y[1] = b[0];
                x[2] = a[2]; y[2] = b[0];
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_mult
        fixed_mult #(
            .TOTAL_PREC (TOTAL_PREC),
            .FRAC_BITS  (FRAC_BITS)
        ) u_mult (
            .x (x[gi]),
            .y (y[gi]),
            .p (p[gi])
        );
    end

endmodule

// File: rtl/fixed_vec3_unit.sv
// fixed_vec3_unit
//   Three-stage fixed-point 3-vector unit (cross / dot / scale) with a
//   valid/ready handshake and a sideband tag. All stages advance together
//   when the output register is empty or being drained; bubbles are kept.
//   Build option FIXED_VEC3_SAT_EN: products and final sums saturate instead
//   of wrapping (latency unchanged).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake
//   in_op               : 00 cross, 01 dot, 10 scale, 11 reserved (result 0)
//   in_tag              : sideband returned unchanged on out_tag
//   a, b                : signed operand vectors
//   out_valid/out_ready : output handshake
//   out_tag, res        : result tag and vector
module fixed_vec3_unit
    import fixed_vec3_pkg::*;
#(
    parameter int TOTAL_PREC = 27,
    parameter int FRAC_BITS  = 22,
    parameter int TAG_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic signed [TOTAL_PREC-1:0] a [3],
    input  logic signed [TOTAL_PREC-1:0] b [3],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [TAG_W-1:0]             out_tag,
    output logic signed [TOTAL_PREC-1:0] res [3]
);

    // Two guard bits cover the worst case of a three-term dot sum.
    localparam int SW = TOTAL_PREC + 2;

    logic adv;

    logic                         s1_valid_q, s1_valid_d;
    logic signed [TOTAL_PREC-1:0] s1_a_q [3], s1_a_d [3];
    logic signed [TOTAL_PREC-1:0] s1_b_q [3], s1_b_d [3];
    vec_op_e                      s1_op_q, s1_op_d;
    logic [TAG_W-1:0]             s1_tag_q, s1_tag_d;

    logic                         s2_valid_q, s2_valid_d;
    logic signed [TOTAL_PREC-1:0] s2_prod_q [6], s2_prod_d [6];
    vec_op_e                      s2_op_q, s2_op_d;
    logic [TAG_W-1:0]             s2_tag_q, s2_tag_d;

    logic                         out_valid_q, out_valid_d;
    logic signed [TOTAL_PREC-1:0] res_q [3], res_d [3];
    logic [TAG_W-1:0]             out_tag_q, out_tag_d;

    logic signed [TOTAL_PREC-1:0] prod_w [6];
    logic signed [TOTAL_PREC-1:0] comb_res [3];

    function automatic logic signed [SW-1:0] ext(input logic signed [TOTAL_PREC-1:0] v);
        return SW'(v);
    endfunction

    function automatic logic signed [TOTAL_PREC-1:0] fin(input logic signed [SW-1:0] v);
`ifdef FIXED_VEC3_SAT_EN
        return TOTAL_PREC'(sat_clip(64'(v), TOTAL_PREC));
`else
        return TOTAL_PREC'(v);
`endif
    endfunction

    assign adv = !out_valid_q || out_ready;
    // Reset drains everything, so the input side is advertised ready while
    // reset is held regardless of the stale output state.
    assign in_ready = adv || rst;

    fixed_vec3_prod #(
        .TOTAL_PREC (TOTAL_PREC),
        .FRAC_BITS  (FRAC_BITS)
    ) u_prod (
        .op (s1_op_q),
        .a  (s1_a_q),
        .b  (s1_b_q),
        .p  (prod_w)
    );

    always_comb begin
        comb_res = '{default: '0};
        case (s2_op_q)
            OP_CROSS: begin
                comb_res[0] = fin(ext(s2_prod_q[0]) - ext(s2_prod_q[1]));
                comb_res[1] = fin(ext(s2_prod_q[2]) - ext(s2_prod_q[3]));
                comb_res[2] = fin(ext(s2_prod_q[4]) - ext(s2_prod_q[5]));
            end
            OP_DOT: begin
                comb_res[0] = fin(ext(s2_prod_q[0]) + ext(s2_prod_q[1]) + ext(s2_prod_q[2]));
            end
            OP_SCALE: begin
                comb_res[0] = s2_prod_q[0];
                comb_res[1] = s2_prod_q[1];
                comb_res[2] = s2_prod_q[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_prod_d   = s2_prod_q;
        s2_op_d     = s2_op_q;
        s2_tag_d    = s2_tag_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        out_tag_d   = out_tag_q;
        if (adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d   = a;
                s1_b_d   = b;
                s1_op_d  = vec_op_e'(in_op);
                s1_tag_d = in_tag;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_d = prod_w;
                s2_op_d   = s1_op_q;
                s2_tag_d  = s1_tag_q;
            end
            out_valid_d = s2_valid_q;
            // A bubble leaves the last result on res.
            if (s2_valid_q) begin
                res_d     = comb_res;
                out_tag_d = s2_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '{default: '0};
            s1_b_q      <= '{default: '0};
            s1_op_q     <= OP_CROSS;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= '{default: '0};
            s2_op_q     <= OP_CROSS;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '{default: '0};
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_prod_q   <= s2_prod_d;
            s2_op_q     <= s2_op_d;
            s2_tag_q    <= s2_tag_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign res       = res_q;

endmodule

// File: tb/tb_fixed_vec3_unit.sv
// tb_fixed_vec3_unit
//   Directed and randomized checks of fixed_vec3_unit against an arithmetic
//   reference model and an in-order expected-result queue.
//   Honours FIXED_VEC3_SAT_EN for the expected arithmetic.
module tb_fixed_vec3_unit;

    localparam int     P    = 27;
    localparam int     F    = 22;
    localparam int     TW   = 8;
    localparam longint ONE  = 64'sd4194304;
    localparam longint MODV = 64'sd1 <<< P;
    localparam longint HALF = 64'sd1 <<< (P - 1);

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_op;
    logic [TW-1:0]       in_tag;
    logic signed [P-1:0] a_in [3];
    logic signed [P-1:0] b_in [3];
    logic                out_valid;
    logic                out_ready;
    logic [TW-1:0]       out_tag;
    logic signed [P-1:0] res_out [3];

    typedef struct {
        logic [TW-1:0] tag;
        longint        r0;
        longint        r1;
        longint        r2;
    } exp_t;

    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;
    int   recv  = 0;

    fixed_vec3_unit #(
        .TOTAL_PREC (P),
        .FRAC_BITS  (F),
        .TAG_W      (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .a         (a_in),
        .b         (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .res       (res_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic longint wrapp(input longint v);
        longint m;
        m = v % MODV;
        if (m < 0) m = m + MODV;
        if (m >= HALF) m = m - MODV;
        return m;
    endfunction

    function automatic longint clipp(input longint v);
        if (v > HALF - 1) return HALF - 1;
        if (v < -HALF) return -HALF;
        return v;
    endfunction

    function automatic longint narrow(input longint v);
`ifdef FIXED_VEC3_SAT_EN
        return clipp(v);
`else
        return wrapp(v);
`endif
    endfunction

    function automatic longint fmul(input longint x, input longint y);
        return narrow((x * y) >>> F);
    endfunction

    task automatic model(input int op, input longint a0, input longint a1, input longint a2,
                         input longint b0, input longint b1, input longint b2,
                         output longint r0, output longint r1, output longint r2);
        r0 = 0; r1 = 0; r2 = 0;
        case (op)
            0: begin
                r0 = narrow(fmul(a1, b2) - fmul(a2, b1));
                r1 = narrow(fmul(a2, b0) - fmul(a0, b2));
                r2 = narrow(fmul(a0, b1) - fmul(a1, b0));
            end
            1: r0 = narrow(fmul(a0, b0) + fmul(a1, b1) + fmul(a2, b2));
            2: begin
                r0 = fmul(a0, b0);
                r1 = fmul(a1, b0);
                r2 = fmul(a2, b0);
            end
            default: ;
        endcase
    endtask

    function automatic longint rnd_val();
        if ($urandom_range(0, 1) == 1)
            return wrapp(longint'($urandom()));
        return longint'($urandom_range(0, 32'h3FF_FFFF)) - 64'sd33554432;
    endfunction

    task automatic rnd_operands();
        for (int i = 0; i < 3; i++) begin
            a_in[i] = P'(rnd_val());
            b_in[i] = P'(rnd_val());
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
        end
    endtask

    // One clock: sample handshakes just before the edge, score outputs,
    // record accepted inputs, then return at the following falling edge.
    task automatic cycle(output bit fired);
        exp_t e;
        exp_t n;
        #1;
        fired = in_valid && in_ready && !rst;
        if (out_valid && out_ready && !rst) begin
            check("out_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_res0", res_out[0], e.r0);
                check("out_res1", res_out[1], e.r1);
                check("out_res2", res_out[2], e.r2);
                check("out_tag", out_tag, e.tag);
                recv++;
            end
        end
        if (fired) begin
            n.tag = in_tag;
            model(int'(in_op), longint'(a_in[0]), longint'(a_in[1]), longint'(a_in[2]),
                  longint'(b_in[0]), longint'(b_in[1]), longint'(b_in[2]), n.r0, n.r1, n.r2);
            sb.push_back(n);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_single(input string nm, input logic [1:0] op, input logic [TW-1:0] tg,
                              input longint a0, input longint a1, input longint a2,
                              input longint b0, input longint b1, input longint b2,
                              input longint e0, input longint e1, input longint e2);
        bit f;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_tag    = tg;
        a_in[0] = P'(a0); a_in[1] = P'(a1); a_in[2] = P'(a2);
        b_in[0] = P'(b0); b_in[1] = P'(b1); b_in[2] = P'(b2);
        cycle(f);
        check({nm, "_accept"}, f, 1);
        in_valid = 1'b0;
        check({nm, "_lat1"}, out_valid, 0);
        cycle(f);
        check({nm, "_lat2"}, out_valid, 0);
        cycle(f);
        check({nm, "_valid"}, out_valid, 1);
        check({nm, "_res0"}, res_out[0], e0);
        check({nm, "_res1"}, res_out[1], e1);
        check({nm, "_res2"}, res_out[2], e2);
        check({nm, "_tag"}, out_tag, tg);
        cycle(f);
        check({nm, "_one_cycle"}, out_valid, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit     f;
        int     sent;
        int     base;
        int     stall_left;
        longint ovf_exp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_tag    = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end

        @(negedge clk);
        cycle(f);
        cycle(f);
        check("rst_out_valid", out_valid, 0);
        check("rst_res0", res_out[0], 0);
        check("rst_res1", res_out[1], 0);
        check("rst_res2", res_out[2], 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        run_single("cross", 2'd0, 8'h5A, ONE, 0, 0, 0, ONE, 0, 0, 0, ONE);
        run_single("dot", 2'd1, 8'h11, ONE, 2 * ONE, 3 * ONE, ONE / 2, ONE / 2, ONE / 2,
                   12582912, 0, 0);
        run_single("scale", 2'd2, 8'h22, ONE, 2 * ONE, 3 * ONE, ONE / 2, ONE / 2, ONE / 2,
                   2097152, 4194304, 6291456);
`ifdef FIXED_VEC3_SAT_EN
        ovf_exp = 67108863;
`else
        ovf_exp = -20971520;
`endif
        run_single("overflow", 2'd1, 8'h44, 3 * ONE, 3 * ONE, 3 * ONE, 3 * ONE, 3 * ONE, 3 * ONE,
                   ovf_exp, 0, 0);
        run_single("reserved", 2'd3, 8'h33, ONE, -ONE, 5 * ONE, 7 * ONE, ONE / 4, -3 * ONE,
                   0, 0, 0);

        // Streaming with a 4-cycle stall on the second result.
        sent       = 0;
        base       = recv;
        stall_left = 4;
        rnd_operands();
        for (int cyc = 0; cyc < 80 && (recv - base) < 8; cyc++) begin
            out_ready = 1'b1;
            if (sent < 8) begin
                in_valid = 1'b1;
                in_op    = 2'd0;
                in_tag   = TW'(sent);
            end else begin
                in_valid = 1'b0;
            end
            if ((recv - base) == 1 && out_valid === 1'b1 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                #1;
                check("stall_in_ready", in_ready, 0);
                if (sb.size() > 0) begin
                    check("stall_res0", res_out[0], sb[0].r0);
                    check("stall_res1", res_out[1], sb[0].r1);
                    check("stall_res2", res_out[2], sb[0].r2);
                    check("stall_tag", out_tag, sb[0].tag);
                end
            end
            cycle(f);
            if (f) begin
                sent++;
                rnd_operands();
            end
        end
        in_valid = 1'b0;
        check("stream_count", recv - base, 8);
        check("stream_stall_done", stall_left, 0);
        check("stream_queue_empty", sb.size(), 0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 60; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_tag    = TW'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            rnd_operands();
            cycle(f);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 12 && sb.size() > 0; c++) begin
            cycle(f);
        end
        check("random_drain", sb.size(), 0);

        // Reset with two transactions in flight.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 2'd0;
        in_tag    = 8'hA1;
        rnd_operands();
        cycle(f);
        in_tag = 8'hA2;
        rnd_operands();
        cycle(f);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_in_ready_during", in_ready, 1);
        cycle(f);
        sb.delete();
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_res0", res_out[0], 0);
        check("midrst_res1", res_out[1], 0);
        check("midrst_res2", res_out[2], 0);
        check("midrst_out_tag", out_tag, 0);
        check("midrst_in_ready", in_ready, 1);
        for (int c = 0; c < 6; c++) begin
            check("midrst_no_emerge", out_valid, 0);
            cycle(f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
